slurm16_flash_dma: RTL and testbench

Flash-to-RAM DMA engine that drives the flash write port of `slurm16_memory_arbiter`. It accepts a byte stream from the SPI flash reader and packs the bytes little-endian into 16-bit words. It buffers the words in a small FIFO and writes them to consecutive word addresses through the arbiter's `fl_*` valid/ready write handshake. The CPU programs a start address and word count, pulses `start`, and watches `busy`/`done`.

---
 rtl/slurm16_flash_dma.sv | 160 ++++++++++++++++
 tb/tb_slurm16_flash_dma.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm16_flash_dma.sv
// slurm16_flash_dma: flash-to-RAM DMA engine.
// Packs an incoming byte stream little-endian into 16-bit words, buffers them
// in a small FIFO and writes them to consecutive word addresses through the
// arbiter's fl_* write port.
//
// Handshakes: a byte transfers on a rising edge where byte_valid && byte_ready;
// a write transfers on a rising edge where fl_wvalid && fl_wready. Once
// fl_wvalid is raised, fl_wvalid/address/data hold until that transfer (or RST).
module slurm16_flash_dma #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dma_count,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] fl_memory_address,
   output logic [15:0] fl_memory_data,
   output logic        fl_wvalid,
   input  logic        fl_wready,
   output logic        busy,
   output logic        done,
   output logic [15:0] words_remaining
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Transfer control
   logic [15:0] addr_q;
   logic [15:0] count_q;
   logic [15:0] remaining_q;

   // Packer
   logic [15:0] packed_q;
   logic [7:0]  low_q;
   logic        have_low;

   // Word FIFO
   logic [15:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   occ;

   logic fifo_full;
   logic fifo_empty;
   logic start_accept;
   logic byte_fire;
   logic push;
   logic pop;

   assign fifo_full    = (occ == DEPTH_V);
   assign fifo_empty   = (occ == '0);
   assign start_accept = (state == ST_IDLE) && start;

   // Intake depends only on registered state, never on fl_wready.
   assign byte_ready = (state == ST_RUN) && !fifo_full && (packed_q < count_q);
   assign byte_fire  = byte_valid && byte_ready;
   assign push       = byte_fire && have_low;

   assign fl_wvalid         = !fifo_empty;
   assign fl_memory_data    = fifo_empty ? 16'h0000 : mem[rd_ptr];
   assign fl_memory_address = addr_q;
   assign pop               = fl_wvalid && fl_wready;

   assign busy            = (state == ST_RUN);
   assign done            = (state == ST_DONE);
   assign words_remaining = remaining_q;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = (dma_count == 16'h0000) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (pop && (remaining_q == 16'd1)) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Address / count bookkeeping: latch on start, advance on each accepted write
   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q      <= 16'h0000;
         count_q     <= 16'h0000;
         remaining_q <= 16'h0000;
      end else if (start_accept) begin
         addr_q      <= dma_addr;
         count_q     <= dma_count;
         remaining_q <= dma_count;
      end else if (pop) begin
         addr_q      <= addr_q + 16'd1;
         remaining_q <= remaining_q - 16'd1;
      end
   end

   // Byte packer: first byte of a pair is held as the low half
   always_ff @(posedge CLK) begin
      if (RST) begin
         low_q    <= 8'h00;
         have_low <= 1'b0;
         packed_q <= 16'h0000;
      end else if (start_accept) begin
         have_low <= 1'b0;
         packed_q <= 16'h0000;
      end else if (byte_fire) begin
         if (!have_low) begin
            low_q    <= byte_data;
            have_low <= 1'b1;
         end else begin
            have_low <= 1'b0;
            packed_q <= packed_q + 16'd1;
         end
      end
   end

   // FIFO storage; emptiness is governed by the pointers, so no reset here
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= {byte_data, low_q};
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_slurm16_flash_dma.sv
// Testbench for slurm16_flash_dma: directed scenarios plus randomized
// transfers compared against a word-list model built from the source bytes.
module tb_slurm16_flash_dma;

   localparam int FIFO_DEPTH = 4;
   localparam int BUDGET     = 3000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [15:0] dma_addr;
   logic [15:0] dma_count;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic [15:0] fl_memory_address;
   logic [15:0] fl_memory_data;
   logic        fl_wvalid;
   logic        fl_wready;
   logic        busy;
   logic        done;
   logic [15:0] words_remaining;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];   // {address, data} of every expected write, in order
   logic [7:0]  src[$];     // source byte stream for the next transfer

   slurm16_flash_dma #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .start             (start),
      .dma_addr          (dma_addr),
      .dma_count         (dma_count),
      .byte_data         (byte_data),
      .byte_valid        (byte_valid),
      .byte_ready        (byte_ready),
      .fl_memory_address (fl_memory_address),
      .fl_memory_data    (fl_memory_data),
      .fl_wvalid         (fl_wvalid),
      .fl_wready         (fl_wready),
      .busy              (busy),
      .done              (done),
      .words_remaining   (words_remaining)
   );

   // Clock
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      start      = 1'b0;
      dma_addr   = 16'h0000;
      dma_count  = 16'h0000;
      byte_data  = 8'h00;
      byte_valid = 1'b0;
      fl_wready  = 1'b0;
   endtask

   // One transfer: src must already hold at least 2*cnt bytes (extras must stay unconsumed).
   task automatic run_xfer(input logic [15:0] addr, input logic [15:0] cnt, input int stall,
                           input int vpct, input int rpct, input bit poke);
      int          cnt_i;
      int          idx;
      int          cyc;
      int          writes;
      bit          finished;
      bit          hold_pend;
      logic [15:0] hold_a;
      logic [15:0] hold_d;
      logic [15:0] a;
      logic [31:0] got;
      logic [31:0] exp;

      cnt_i = int'(cnt);
      exp_q.delete();
      for (int i = 0; i < cnt_i; i++) begin
         a = addr + 16'(i);
         exp_q.push_back({a, src[2*i+1], src[2*i]});
      end

      @(negedge CLK);
      start     = 1'b1;
      dma_addr  = addr;
      dma_count = cnt;
      @(negedge CLK);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'(cnt != 16'd0));

      idx = 0; cyc = 0; writes = 0; finished = 1'b0; hold_pend = 1'b0;
      hold_a = '0; hold_d = '0;
      while (!finished && cyc < BUDGET) begin
         start = 1'b0;
         if (hold_pend) begin
            chk("hold_wvalid", 32'(fl_wvalid), 32'd1);
            chk("hold_addr", 32'(fl_memory_address), 32'(hold_a));
            chk("hold_data", 32'(fl_memory_data), 32'(hold_d));
         end
         if (done) begin
            byte_valid = 1'b1;
            byte_data  = 8'(($urandom_range(255)));
            fl_wready  = 1'b0;
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_remaining", 32'(words_remaining), 32'd0);
            chk("done_writes", 32'(writes), 32'(cnt_i));
            chk("done_wvalid", 32'(fl_wvalid), 32'd0);
            chk("done_byte_ready", 32'(byte_ready), 32'd0);
            finished = 1'b1;
         end else begin
            byte_valid = (idx < src.size()) && ($urandom_range(99) < vpct);
            byte_data  = (idx < src.size()) ? src[idx] : 8'h00;
            fl_wready  = (cyc >= stall) && ($urandom_range(99) < rpct);
            if (poke && cyc == 3) begin
               start     = 1'b1;
               dma_addr  = ~addr;
               dma_count = cnt + 16'd5;
            end
            if (idx >= 2 * cnt_i) chk("no_extra_byte", 32'(byte_ready), 32'd0);
            if (stall > 0 && cyc == stall - 1) begin
               chk("bp_bytes_taken", 32'(idx),
                   32'(2 * ((cnt_i < FIFO_DEPTH) ? cnt_i : FIFO_DEPTH)));
               chk("bp_byte_ready", 32'(byte_ready), 32'd0);
            end
            if (byte_valid && byte_ready) idx++;
            if (fl_wvalid && fl_wready) begin
               got = {fl_memory_address, fl_memory_data};
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", got, 32'hxxxx_xxxx);
               end else begin
                  exp = exp_q.pop_front();
                  chk("write", got, exp);
               end
               chk("remaining", 32'(words_remaining), 32'(cnt_i - writes));
               writes++;
            end
            hold_pend = fl_wvalid && !fl_wready;
            hold_a    = fl_memory_address;
            hold_d    = fl_memory_data;
         end
         if (!finished) begin
            @(negedge CLK);
            cyc++;
         end
      end
      if (!finished) chk("timeout_no_done", 32'd0, 32'd1);

      @(negedge CLK);
      byte_valid = 1'b0;
      fl_wready  = 1'b0;
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_byte_ready", 32'(byte_ready), 32'd0);
      chk("post_wvalid", 32'(fl_wvalid), 32'd0);
      chk("bytes_consumed", 32'(idx), 32'(2 * cnt_i));
      chk("writes_left", 32'(exp_q.size()), 32'd0);
      if (poke) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("ignored_start_done", 32'(done), 32'd0);
            chk("ignored_start_busy", 32'(busy), 32'd0);
         end
      end
   endtask

   task automatic fill_random(input int n);
      src.delete();
      for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(255)));
   endtask

   task automatic fill_basic();
      src.delete();
      src.push_back(8'h34); src.push_back(8'h12);
      src.push_back(8'h78); src.push_back(8'h56);
      src.push_back(8'hAA); src.push_back(8'hBB);
   endtask

   initial begin
      int          taken;
      logic [15:0] c;

      // Reset
      idle_inputs();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_wvalid", 32'(fl_wvalid), 32'd0);
      chk("rst_addr", 32'(fl_memory_address), 32'd0);
      chk("rst_data", 32'(fl_memory_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_remaining", 32'(words_remaining), 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // Basic transfer with extra trailing bytes that must not be consumed
      fill_basic();
      run_xfer(16'h8000, 16'd2, 0, 100, 100, 1'b0);

      // Backpressure: arbiter stalls for 20 cycles
      fill_random(18);
      run_xfer(16'h1230, 16'd8, 20, 100, 100, 1'b0);

      // Address wrap
      fill_random(4);
      run_xfer(16'hFFFF, 16'd2, 0, 100, 100, 1'b0);

      // Zero count
      fill_random(4);
      run_xfer(16'h4000, 16'd0, 0, 100, 100, 1'b0);

      // Ignored start mid-transfer
      fill_random(12);
      run_xfer(16'h2000, 16'd6, 0, 100, 50, 1'b1);

      // Randomized transfers
      for (int t = 0; t < 8; t++) begin
         c = 16'($urandom_range(9, 1));
         fill_random(2 * int'(c) + 3);
         run_xfer(16'($urandom_range(16'hFFFF)), c, 0,
                  $urandom_range(100, 40), $urandom_range(100, 30), 1'b0);
      end

      // Reset mid-transfer: 3 words queued plus a pending low byte
      @(negedge CLK);
      start     = 1'b1;
      dma_addr  = 16'h5000;
      dma_count = 16'd6;
      @(negedge CLK);
      start = 1'b0;
      taken = 0;
      for (int k = 0; k < 30 && taken < 7; k++) begin
         byte_valid = 1'b1;
         byte_data  = 8'(($urandom_range(255)));
         fl_wready  = 1'b0;
         if (byte_ready) taken++;
         @(negedge CLK);
      end
      byte_valid = 1'b0;
      chk("rstmid_bytes_taken", 32'(taken), 32'd7);
      chk("rstmid_wvalid_before", 32'(fl_wvalid), 32'd1);
      chk("rstmid_remaining_before", 32'(words_remaining), 32'd6);
      RST = 1'b1;
      @(negedge CLK);
      chk("rstmid_wvalid", 32'(fl_wvalid), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_remaining", 32'(words_remaining), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      chk("rstmid_done_after", 32'(done), 32'd0);

      // Clean packer after reset: first byte is the low byte again
      fill_basic();
      run_xfer(16'h8000, 16'd2, 0, 100, 100, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
